// File: rtl/usb_host_piso_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_host_piso_pkg
// Purpose : Shared request-type codes, field constants and FSM encodings for
//           the USB host parallel-in/serial-out field generator.
// Revision: 1.0 - initial release
// ============================================================================
package usb_host_piso_pkg;

  localparam int C_TYPE_W = 3;
  typedef logic [C_TYPE_W-1:0] req_type_t;

  localparam req_type_t C_TYPE_NULL         = 3'd0;
  localparam req_type_t C_TYPE_SYNC         = 3'd1;
  localparam req_type_t C_TYPE_PID_READ     = 3'd2;
  localparam req_type_t C_TYPE_READ_ADDRESS = 3'd3;
  localparam req_type_t C_TYPE_PASS_THROUGH = 3'd4;
  localparam req_type_t C_TYPE_MAX          = 3'd4;

  // Bit 7 set: seven zeros then a one on the wire, LSB first
  localparam logic [7:0] C_SYNC_PATTERN = 8'h80;
  localparam logic [7:0] C_PID_IN       = 8'h69;

  localparam int C_ST_W = 3;
  localparam logic [C_ST_W-1:0] C_ST_IDLE  = 3'd0;
  localparam logic [C_ST_W-1:0] C_ST_LOAD  = 3'd1;
  localparam logic [C_ST_W-1:0] C_ST_SHIFT = 3'd2;
  localparam logic [C_ST_W-1:0] C_ST_STUFF = 3'd3;
  localparam logic [C_ST_W-1:0] C_ST_GAP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/usb_crc5.sv
`default_nettype none
// ============================================================================
// Module  : usb_crc5
// Purpose : Serial USB token CRC5 (x^5+x^2+1, seed all-ones, inverted out).
// Revision: 1.0 - initial release
// ============================================================================
module usb_crc5 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [4:0] crc_out
);

  logic [4:0] r_crc;
  logic       w_fb;

  assign w_fb = data_in ^ r_crc[4];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_crc <= 5'h1F;
    end else if (enable) begin
      r_crc <= {r_crc[3:0], 1'b0} ^ (w_fb ? 5'b00101 : 5'b00000);
    end
  end

  assign crc_out = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_host_piso.sv
`default_nettype none
// ============================================================================
// Module  : usb_host_piso
// Purpose : Serializes SYNC / IN PID / address+endpoint+CRC5 / FIFO bytes,
//           LSB first. Optional bit stuffing via USB_PISO_BIT_STUFF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module usb_host_piso
  import usb_host_piso_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       request_serial_data,
  input  logic [2:0] request_serial_data_type,
  input  logic [6:0] device_address,
  input  logic [3:0] endpoint,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       serial_data,
  output logic       serial_data_val,
  output logic       serial_data_last,
  output logic       serial_data_avail
);

  logic [C_ST_W-1:0] r_state;
  logic [C_ST_W-1:0] w_next_state;
  req_type_t         r_type;
  logic [15:0]       r_shift;
  logic [3:0]        r_count;
  logic [3:0]        r_len_m1;
  logic              r_pt_wait;
  logic              r_more;
  logic              r_rd_d;
  logic [7:0]        r_next_byte;
  logic              r_avail;
  logic [7:0]        w_next_byte;
  logic              w_word_end;
  logic              w_final;
  logic              w_bit;
  logic              w_stuff;
  logic              w_crc_en;
  logic              w_crc_clr;
  logic [2:0]        w_crc_sel;
  logic [4:0]        w_crc;
`ifdef USB_PISO_BIT_STUFF_EN
  logic [2:0]        r_ones;
  logic              r_final;
`endif

  // FIFO data is only valid the cycle after the pop, so hold it for later use
  assign w_next_byte = r_rd_d ? fifo_data : r_next_byte;
  assign w_word_end  = (r_count == r_len_m1);
  assign w_final     = w_word_end && !r_more;
  // CRC bits 11..15 go out c4 first
  assign w_crc_sel   = 3'd7 - r_count[2:0];
  assign w_bit       = (r_type == C_TYPE_READ_ADDRESS && r_count >= 4'd11) ?
                       w_crc[w_crc_sel] : r_shift[0];
  assign w_crc_clr   = (r_state == C_ST_LOAD);
  assign w_crc_en    = (r_state == C_ST_SHIFT) && (r_type == C_TYPE_READ_ADDRESS) &&
                       (r_count < 4'd11);
`ifdef USB_PISO_BIT_STUFF_EN
  assign w_stuff     = (r_ones == 3'd5) && w_bit;
`else
  assign w_stuff     = 1'b0;
`endif
  assign serial_data_avail = r_avail;

  usb_crc5 u_crc5 (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_crc_clr),
    .enable  (w_crc_en),
    .data_in (r_shift[0]),
    .crc_out (w_crc)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= C_ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (request_serial_data && request_serial_data_type != C_TYPE_NULL &&
            request_serial_data_type <= C_TYPE_MAX)
          w_next_state = C_ST_LOAD;
      end
      C_ST_LOAD: begin
        if (!request_serial_data) w_next_state = C_ST_IDLE;
        else begin
          case (r_type)
            C_TYPE_SYNC, C_TYPE_PID_READ, C_TYPE_READ_ADDRESS: w_next_state = C_ST_SHIFT;
            C_TYPE_PASS_THROUGH: begin
              if (r_pt_wait)       w_next_state = C_ST_SHIFT;
              else if (fifo_empty) w_next_state = C_ST_GAP;
            end
            default: w_next_state = C_ST_GAP;
          endcase
        end
      end
      C_ST_SHIFT: begin
        if (!request_serial_data) w_next_state = C_ST_IDLE;
        else if (w_stuff)         w_next_state = C_ST_STUFF;
        else if (w_final)         w_next_state = C_ST_GAP;
      end
`ifdef USB_PISO_BIT_STUFF_EN
      C_ST_STUFF: begin
        if (!request_serial_data) w_next_state = C_ST_IDLE;
        else if (r_final)         w_next_state = C_ST_GAP;
        else                      w_next_state = C_ST_SHIFT;
      end
`endif
      default: w_next_state = C_ST_IDLE;
    endcase
  end

  // Outputs are gated by the request so an abort silences them immediately
  always_comb begin
    fifo_read        = 1'b0;
    serial_data      = 1'b0;
    serial_data_val  = 1'b0;
    serial_data_last = 1'b0;
    case (r_state)
      C_ST_LOAD: begin
        if (request_serial_data && r_type == C_TYPE_PASS_THROUGH && !r_pt_wait) begin
          fifo_read        = !fifo_empty;
          serial_data_last = fifo_empty;
        end
      end
      C_ST_SHIFT: begin
        serial_data      = request_serial_data && w_bit;
        serial_data_val  = request_serial_data;
        serial_data_last = request_serial_data && w_final && !w_stuff;
        fifo_read        = request_serial_data && (r_type == C_TYPE_PASS_THROUGH) &&
                           (r_count == 4'd6) && !fifo_empty;
      end
`ifdef USB_PISO_BIT_STUFF_EN
      C_ST_STUFF: begin
        serial_data_val  = request_serial_data;
        serial_data_last = request_serial_data && r_final;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_type      <= C_TYPE_NULL;
      r_shift     <= 16'h0000;
      r_count     <= 4'd0;
      r_len_m1    <= 4'd0;
      r_pt_wait   <= 1'b0;
      r_more      <= 1'b0;
      r_rd_d      <= 1'b0;
      r_next_byte <= 8'h00;
      r_avail     <= 1'b0;
`ifdef USB_PISO_BIT_STUFF_EN
      r_ones      <= 3'd0;
      r_final     <= 1'b0;
`endif
    end else begin
      r_avail <= ~fifo_empty;
      r_rd_d  <= fifo_read;
      if (r_rd_d) r_next_byte <= fifo_data;
      case (r_state)
        C_ST_IDLE: begin
          r_count   <= 4'd0;
          r_pt_wait <= 1'b0;
          r_more    <= 1'b0;
`ifdef USB_PISO_BIT_STUFF_EN
          r_ones    <= 3'd0;
          r_final   <= 1'b0;
`endif
          if (w_next_state == C_ST_LOAD) r_type <= request_serial_data_type;
        end
        C_ST_LOAD: begin
          r_count <= 4'd0;
          r_more  <= 1'b0;
          case (r_type)
            C_TYPE_SYNC: begin
              r_shift  <= {8'h00, C_SYNC_PATTERN};
              r_len_m1 <= 4'd7;
            end
            C_TYPE_PID_READ: begin
              r_shift  <= {8'h00, C_PID_IN};
              r_len_m1 <= 4'd7;
            end
            C_TYPE_READ_ADDRESS: begin
              r_shift  <= {5'b00000, endpoint, device_address};
              r_len_m1 <= 4'd15;
            end
            C_TYPE_PASS_THROUGH: begin
              if (r_pt_wait) begin
                r_shift  <= {8'h00, w_next_byte};
                r_len_m1 <= 4'd7;
              end else begin
                r_pt_wait <= fifo_read;
              end
            end
            default: ;
          endcase
        end
        C_ST_SHIFT: begin
          if (w_word_end && r_more) begin
            r_shift <= {8'h00, w_next_byte};
            r_count <= 4'd0;
            r_more  <= 1'b0;
          end else begin
            r_shift <= {1'b0, r_shift[15:1]};
            r_count <= r_count + 4'd1;
          end
          if (fifo_read) r_more <= 1'b1;
`ifdef USB_PISO_BIT_STUFF_EN
          r_final <= w_final;
          r_ones  <= w_stuff ? 3'd0 : (w_bit ? r_ones + 3'd1 : 3'd0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_host_piso.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_host_piso
// Purpose : Directed self-checking bench for usb_host_piso.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb_host_piso;

  localparam logic [2:0] T_SYNC = 3'd1;
  localparam logic [2:0] T_PID  = 3'd2;
  localparam logic [2:0] T_RA   = 3'd3;
  localparam logic [2:0] T_PT   = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       request_serial_data = 1'b0;
  logic [2:0] request_serial_data_type = 3'd0;
  logic [6:0] device_address = 7'd0;
  logic [3:0] endpoint = 4'd0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_read;
  logic       serial_data;
  logic       serial_data_val;
  logic       serial_data_last;
  logic       serial_data_avail;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];

  int          cap_n;
  logic [31:0] cap_word;
  int          cap_first;
  int          cap_last_cycle;
  int          cap_last_cnt;
  int          cap_rd;
  int          cap_rd_bad;
  logic        cap_gap_busy;
  logic        cap_timeout;

  usb_host_piso dut (
    .clock                    (clock),
    .reset                    (reset),
    .request_serial_data      (request_serial_data),
    .request_serial_data_type (request_serial_data_type),
    .device_address           (device_address),
    .endpoint                 (endpoint),
    .fifo_data                (fifo_data),
    .fifo_empty               (fifo_empty),
    .fifo_read                (fifo_read),
    .serial_data              (serial_data),
    .serial_data_val          (serial_data_val),
    .serial_data_last         (serial_data_last),
    .serial_data_avail        (serial_data_avail)
  );

  always #5 clock = ~clock;

  // Called just after a negedge sample; moves to posedge+1 and models the FIFO pop
  task automatic advance();
    logic rd;
    rd = fifo_read;
    @(posedge clock);
    #1;
    if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Records one field; drops the request after the last flag and samples the gap cycle
  task automatic capture(input int max_cycles, input logic [2:0] alt_type);
    logic done;
    cap_n = 0; cap_word = '0; cap_first = -1; cap_last_cycle = -1;
    cap_last_cnt = 0; cap_rd = 0; cap_rd_bad = 0; cap_gap_busy = 1'b1; cap_timeout = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clock);
      if (serial_data_val) begin
        if (cap_first < 0) cap_first = c;
        if (cap_n < 32) cap_word[cap_n] = serial_data;
        cap_n++;
      end
      if (serial_data_last) begin cap_last_cnt++; cap_last_cycle = c; end
      if (fifo_read) cap_rd++;
      if (fifo_read && fifo_empty) cap_rd_bad++;
      done = serial_data_last;
      advance();
      if (c == 0) request_serial_data_type = alt_type;
      if (done) begin
        request_serial_data = 1'b0;
        @(negedge clock);
        cap_gap_busy = serial_data_val | serial_data_last;
        advance();
        cap_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_empty = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({fifo_read, serial_data, serial_data_val, serial_data_last, serial_data_avail} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {fifo_read, serial_data, serial_data_val, serial_data_last, serial_data_avail});
    end
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); @(negedge clock);
    n_tests++;
    if (serial_data_avail !== 1'b1) begin
      n_fail++; $display("FAIL avail_set: got %b expected 1", serial_data_avail);
    end
    n_tests++;
    if (serial_data_val !== 1'b0) begin
      n_fail++; $display("FAIL idle_val: got %b expected 0", serial_data_val);
    end
    fifo_empty = 1'b1;
    @(posedge clock); @(negedge clock);
    n_tests++;
    if (serial_data_avail !== 1'b0) begin
      n_fail++; $display("FAIL avail_clear: got %b expected 0", serial_data_avail);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_sync();
    request_serial_data = 1'b1; request_serial_data_type = T_SYNC;
    capture(40, T_SYNC);
    n_tests++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL sync_timeout: got no last within 40 cycles"); end
    n_tests++;
    if (cap_n !== 8) begin n_fail++; $display("FAIL sync_len: got %0d expected 8", cap_n); end
    n_tests++;
    if (cap_word[7:0] !== 8'h80) begin n_fail++; $display("FAIL sync_bits: got %h expected 80", cap_word[7:0]); end
    n_tests++;
    if (cap_first !== 2) begin n_fail++; $display("FAIL sync_latency: got %0d expected 2", cap_first); end
    n_tests++;
    if (cap_last_cycle !== cap_first + 7 || cap_last_cnt !== 1) begin
      n_fail++; $display("FAIL sync_last: got cycle %0d count %0d expected cycle %0d count 1",
                         cap_last_cycle, cap_last_cnt, cap_first + 7);
    end
    n_tests++;
    if (cap_gap_busy !== 1'b0) begin n_fail++; $display("FAIL sync_gap: got %b expected 0", cap_gap_busy); end
  endtask

  task automatic test_pid_latch();
    // type changed to SYNC after LOAD; the latched PID must still be sent
    request_serial_data = 1'b1; request_serial_data_type = T_PID;
    capture(40, T_SYNC);
    n_tests++;
    if (cap_n !== 8 || cap_word[7:0] !== 8'h69) begin
      n_fail++; $display("FAIL pid_bits: got %0d bits %h expected 8 bits 69", cap_n, cap_word[7:0]);
    end
    n_tests++;
    if (cap_last_cycle !== cap_first + 7 || cap_last_cnt !== 1) begin
      n_fail++; $display("FAIL pid_last: got cycle %0d count %0d expected cycle %0d count 1",
                         cap_last_cycle, cap_last_cnt, cap_first + 7);
    end
  endtask

  task automatic test_read_address();
    logic [15:0] exp_word;
    logic [4:0]  exp_tail;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        device_address = 7'h15; endpoint = 4'hE; exp_word = 16'hEF15; exp_tail = 5'b10111;
      end else begin
        device_address = 7'h00; endpoint = 4'h0; exp_word = 16'h1000; exp_tail = 5'b01000;
      end
      request_serial_data = 1'b1; request_serial_data_type = T_RA;
      capture(60, T_RA);
      n_tests++;
      if (cap_n !== 16 || cap_word[15:0] !== exp_word) begin
        n_fail++; $display("FAIL ra_word[%0d]: got %0d bits %h expected 16 bits %h",
                           i, cap_n, cap_word[15:0], exp_word);
      end
      n_tests++;
      if ({cap_word[11], cap_word[12], cap_word[13], cap_word[14], cap_word[15]} !== exp_tail) begin
        n_fail++; $display("FAIL ra_crc[%0d]: got %b expected %b", i,
                           {cap_word[11], cap_word[12], cap_word[13], cap_word[14], cap_word[15]}, exp_tail);
      end
      n_tests++;
      if (cap_last_cycle !== cap_first + 15) begin
        n_fail++; $display("FAIL ra_last[%0d]: got %0d expected %0d", i, cap_last_cycle, cap_first + 15);
      end
    end
  endtask

  task automatic test_pass_through();
    fifo_q = '{8'hA5, 8'h3C}; fifo_empty = 1'b0;
    request_serial_data = 1'b1; request_serial_data_type = T_PT;
    capture(60, T_PT);
    n_tests++;
    if (cap_n !== 16 || cap_word[15:0] !== 16'h3CA5) begin
      n_fail++; $display("FAIL pt_word: got %0d bits %h expected 16 bits 3ca5", cap_n, cap_word[15:0]);
    end
    n_tests++;
    if (cap_rd !== 2 || cap_rd_bad !== 0) begin
      n_fail++; $display("FAIL pt_reads: got %0d (%0d while empty) expected 2 (0)", cap_rd, cap_rd_bad);
    end
    n_tests++;
    if (cap_first !== 3) begin n_fail++; $display("FAIL pt_latency: got %0d expected 3", cap_first); end
    n_tests++;
    if (cap_last_cycle !== cap_first + cap_n - 1 || cap_last_cnt !== 1) begin
      n_fail++; $display("FAIL pt_contig_last: got last %0d count %0d expected %0d count 1",
                         cap_last_cycle, cap_last_cnt, cap_first + cap_n - 1);
    end
  endtask

  task automatic test_pass_through_ones();
    int          exp_n;
    logic [31:0] exp_word;
`ifdef USB_PISO_BIT_STUFF_EN
    exp_n = 9; exp_word = 32'h1BF;
`else
    exp_n = 8; exp_word = 32'hFF;
`endif
    fifo_q = '{8'hFF}; fifo_empty = 1'b0;
    request_serial_data = 1'b1; request_serial_data_type = T_PT;
    capture(60, T_PT);
    n_tests++;
    if (cap_n !== exp_n || cap_word !== exp_word) begin
      n_fail++; $display("FAIL ones_bits: got %0d bits %h expected %0d bits %h", cap_n, cap_word, exp_n, exp_word);
    end
    n_tests++;
    if (cap_last_cycle !== cap_first + exp_n - 1 || cap_rd !== 1) begin
      n_fail++; $display("FAIL ones_last: got last %0d reads %0d expected last %0d reads 1",
                         cap_last_cycle, cap_rd, cap_first + exp_n - 1);
    end
  endtask

  task automatic test_pass_through_empty();
    fifo_q.delete(); fifo_empty = 1'b1;
    request_serial_data = 1'b1; request_serial_data_type = T_PT;
    capture(20, T_PT);
    n_tests++;
    if (cap_n !== 0 || cap_last_cnt !== 1 || cap_last_cycle !== 1) begin
      n_fail++; $display("FAIL pt_empty: got val %0d last %0d at %0d expected val 0 last 1 at 1",
                         cap_n, cap_last_cnt, cap_last_cycle);
    end
    n_tests++;
    if (cap_rd !== 0 || cap_gap_busy !== 1'b0) begin
      n_fail++; $display("FAIL pt_empty_rd: got reads %0d gap %b expected 0 0", cap_rd, cap_gap_busy);
    end
  endtask

  task automatic test_abort();
    logic [2:0] bits;
    int         vals;
    bits = 3'b000; vals = 0;
    request_serial_data = 1'b1; request_serial_data_type = T_PID;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c >= 2) begin bits[c-2] = serial_data; vals += int'(serial_data_val); end
      advance();
    end
    request_serial_data = 1'b0;
    @(negedge clock);
    n_tests++;
    if (bits !== 3'b001 || vals !== 3) begin
      n_fail++; $display("FAIL abort_prefix: got %b (%0d val) expected 001 (3 val)", bits, vals);
    end
    n_tests++;
    if ({serial_data_val, serial_data_last, fifo_read} !== 3'b000) begin
      n_fail++; $display("FAIL abort_drop: got %b expected 000", {serial_data_val, serial_data_last, fifo_read});
    end
    advance();
    request_serial_data = 1'b1; request_serial_data_type = T_SYNC;
    capture(40, T_SYNC);
    n_tests++;
    if (cap_n !== 8 || cap_word[7:0] !== 8'h80 || cap_first !== 2) begin
      n_fail++; $display("FAIL abort_resync: got %0d bits %h first %0d expected 8 bits 80 first 2",
                         cap_n, cap_word[7:0], cap_first);
    end
  endtask

  task automatic test_reset_mid();
    int busy;
    busy = 0;
    request_serial_data = 1'b1; request_serial_data_type = T_SYNC;
    for (int c = 0; c < 4; c++) begin @(negedge clock); advance(); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    n_tests++;
    if ({serial_data_val, serial_data_last, serial_data, fifo_read} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid: got %b expected 0000",
                         {serial_data_val, serial_data_last, serial_data, fifo_read});
    end
    @(posedge clock); #1;
    reset = 1'b0; request_serial_data = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      busy += int'(serial_data_val | serial_data_last);
      advance();
    end
    n_tests++;
    if (busy !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d active cycles expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_pid_latch();
    test_read_address();
    test_pass_through();
    test_pass_through_ones();
    test_pass_through_empty();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
